// File: rtl/pc_next_unit_if.sv
// EX-stage operand bundle into the next-PC unit and the fetch/redirect results coming back out.
// master drives the resolving instruction's operands; slave is the next-PC unit itself.
interface pc_next_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             branch;
  logic             jump;
  logic             jalr;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  ex_pc;

  logic [XLEN-1:0]  pc;
  logic             pc_src;
  logic [XLEN-1:0]  target;
  logic             flush;
  logic             trap;
  logic [XLEN-1:0]  trap_addr;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output stall, branch, jump, jalr, funct3, rs1_data, rs2_data, imm, ex_pc,
    input  pc, pc_src, target, flush, trap, trap_addr, br_cnt, taken_cnt
  );

  modport slave (
    input  stall, branch, jump, jalr, funct3, rs1_data, rs2_data, imm, ex_pc,
    output pc, pc_src, target, flush, trap, trap_addr, br_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC/redirect unit: resolves RV32I branches and JAL/JALR, owns the fetch PC, traps misaligned targets.
// pc_src/target are combinational; pc, flush, trap and the statistics counters update one edge later.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter bit              COMPRESSED   = 1'b0,
  parameter int              CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pc_next_unit_if.slave      bus
);

  logic             cond;
  logic             taken;
  logic             mis;
  logic             count_br;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  tgt;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [XLEN-1:0]  trap_addr_q, trap_addr_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    cond = 1'b0;
    unique case (bus.funct3)
      3'b000:  cond = (bus.rs1_data == bus.rs2_data);
      3'b001:  cond = (bus.rs1_data != bus.rs2_data);
      3'b100:  cond = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  cond = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  cond = (bus.rs1_data <  bus.rs2_data);
      3'b111:  cond = (bus.rs1_data >= bus.rs2_data);
      default: cond = 1'b0;
    endcase
  end

  // A jump wins over a simultaneous branch; jalr only matters when jump is set.
  assign taken    = bus.jump | (bus.branch & cond);
  assign jalr_sum = bus.rs1_data + bus.imm;
  assign tgt      = (bus.jump & bus.jalr) ? {jalr_sum[XLEN-1:1], 1'b0} : bus.ex_pc + bus.imm;
  assign mis      = taken & (COMPRESSED ? 1'b0 : tgt[1]);
  assign count_br = bus.branch & ~bus.jump;

  always_comb begin
    pc_d        = pc_q + XLEN'(4);
    flush_d     = taken;
    trap_d      = mis;
    trap_addr_d = trap_addr_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    // Redirects are never deferred by stall: the resolving instruction leaves EX this cycle.
    if (mis) begin
      pc_d        = TRAP_VECTOR;
      trap_addr_d = tgt;
    end else if (taken) begin
      pc_d = tgt;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end

    if (count_br) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (cond && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_src    = taken;
  assign bus.target    = tgt;
  assign bus.flush     = flush_q;
  assign bus.trap      = trap_q;
  assign bus.trap_addr = trap_addr_q;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: three instances (base, compressed, 2-bit counters) share one stimulus stream.
// Checked against a reference model plus constant expectations for the directed scenarios.
module tb_pc_next_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_next_unit_if #(.XLEN(32), .CNT_W(16)) if0 ();
  pc_next_unit_if #(.XLEN(32), .CNT_W(16)) if1 ();
  pc_next_unit_if #(.XLEN(32), .CNT_W(2))  if2 ();

  assign if1.stall = if0.stall;       assign if2.stall = if0.stall;
  assign if1.branch = if0.branch;     assign if2.branch = if0.branch;
  assign if1.jump = if0.jump;         assign if2.jump = if0.jump;
  assign if1.jalr = if0.jalr;         assign if2.jalr = if0.jalr;
  assign if1.funct3 = if0.funct3;     assign if2.funct3 = if0.funct3;
  assign if1.rs1_data = if0.rs1_data; assign if2.rs1_data = if0.rs1_data;
  assign if1.rs2_data = if0.rs2_data; assign if2.rs2_data = if0.rs2_data;
  assign if1.imm = if0.imm;           assign if2.imm = if0.imm;
  assign if1.ex_pc = if0.ex_pc;       assign if2.ex_pc = if0.ex_pc;

  pc_next_unit #(.XLEN(32), .COMPRESSED(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pc_next_unit #(.XLEN(32), .COMPRESSED(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pc_next_unit #(.XLEN(32), .COMPRESSED(1'b0), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        br, j, jr;
    logic [2:0]  f3;
    logic [31:0] a, b, im, ep;
    logic        exp_src;
    logic [31:0] exp_tgt;
  } vec_t;
  vec_t vecs[11];

  // Reference model state, one slot per instance.
  logic [31:0] m_pc[3];
  logic        m_flush[3];
  logic        m_trap[3];
  logic [31:0] m_ta[3];
  int          m_br[3];
  int          m_tk[3];
  bit          comp[3] = '{1'b0, 1'b1, 1'b0};
  int          cmax[3] = '{65535, 65535, 3};
  logic        m_src;
  logic [31:0] m_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit r, s, b, j, jr, input logic [2:0] f3,
                       input logic [31:0] a, bb, im, ep);
    @(negedge clk);
    rst = r;
    if0.stall = s; if0.branch = b; if0.jump = j; if0.jalr = jr; if0.funct3 = f3;
    if0.rs1_data = a; if0.rs2_data = bb; if0.imm = im; if0.ex_pc = ep;
  endtask

  task automatic comb_check();
    longint sum;
    #2;
    m_src = if0.jump | (if0.branch & ref_cond(if0.funct3, if0.rs1_data, if0.rs2_data));
    if (if0.jump && if0.jalr) begin
      sum = (longint'(if0.rs1_data) + longint'(if0.imm)) % 64'h1_0000_0000;
      m_t = 32'(sum) & 32'hFFFF_FFFE;
    end else begin
      sum = (longint'(if0.ex_pc) + longint'(if0.imm)) % 64'h1_0000_0000;
      m_t = 32'(sum);
    end
    chk("pc_src0", 32'(if0.pc_src), 32'(m_src)); chk("target0", if0.target, m_t);
    chk("pc_src1", 32'(if1.pc_src), 32'(m_src)); chk("target1", if1.target, m_t);
    chk("pc_src2", 32'(if2.pc_src), 32'(m_src)); chk("target2", if2.target, m_t);
  endtask

  task automatic chk_regs(input int k, input logic [31:0] pc, input logic fl, input logic tr,
                          input logic [31:0] ta, input logic [31:0] brc, input logic [31:0] tkc);
    chk($sformatf("pc%0d", k), pc, m_pc[k]);
    chk($sformatf("flush%0d", k), 32'(fl), 32'(m_flush[k]));
    chk($sformatf("trap%0d", k), 32'(tr), 32'(m_trap[k]));
    chk($sformatf("trap_addr%0d", k), ta, m_ta[k]);
    chk($sformatf("br_cnt%0d", k), brc, 32'(m_br[k]));
    chk($sformatf("taken_cnt%0d", k), tkc, 32'(m_tk[k]));
  endtask

  task automatic clk_check();
    logic [31:0] npc[3];
    bit nmis[3];
    bit c;
    c = ref_cond(if0.funct3, if0.rs1_data, if0.rs2_data);
    for (int k = 0; k < 3; k++) begin
      nmis[k] = m_src && !comp[k] && m_t[1];
      if (nmis[k])           npc[k] = 32'h100;
      else if (m_src)        npc[k] = m_t;
      else if (if0.stall)    npc[k] = m_pc[k];
      else                   npc[k] = 32'((longint'(m_pc[k]) + 4) % 64'h1_0000_0000);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_pc[k] = 32'h0; m_flush[k] = 1'b0; m_trap[k] = 1'b0; m_ta[k] = 32'h0; m_br[k] = 0; m_tk[k] = 0;
      end else begin
        m_pc[k] = npc[k];
        m_flush[k] = m_src;
        m_trap[k] = nmis[k];
        if (nmis[k]) m_ta[k] = m_t;
        if (if0.branch && !if0.jump) begin
          if (m_br[k] < cmax[k]) m_br[k]++;
          if (c && m_tk[k] < cmax[k]) m_tk[k]++;
        end
      end
    end
    chk_regs(0, if0.pc, if0.flush, if0.trap, if0.trap_addr, 32'(if0.br_cnt), 32'(if0.taken_cnt));
    chk_regs(1, if1.pc, if1.flush, if1.trap, if1.trap_addr, 32'(if1.br_cnt), 32'(if1.taken_cnt));
    chk_regs(2, if2.pc, if2.flush, if2.trap, if2.trap_addr, 32'(if2.br_cnt), 32'(if2.taken_cnt));
  endtask

  task automatic step(input bit r, s, b, j, jr, input logic [2:0] f3,
                      input logic [31:0] a, bb, im, ep);
    drive(r, s, b, j, jr, f3, a, bb, im, ep);
    comb_check();
    clk_check();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    vecs[0]  = '{1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1, 32'h120};
    vecs[1]  = '{1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h20, 32'h100, 0, 32'h120};
    vecs[2]  = '{1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 1, 32'h50};
    vecs[3]  = '{1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 0, 32'h50};
    vecs[4]  = '{1, 0, 0, 3'd5, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h0, 1, 32'h8};
    vecs[5]  = '{1, 0, 0, 3'd7, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h0, 0, 32'h8};
    vecs[6]  = '{1, 0, 0, 3'd3, 32'd9, 32'd9, 32'h8, 32'h0, 0, 32'h8};
    vecs[7]  = '{1, 1, 0, 3'd1, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'h200, 1, 32'h1FC};
    vecs[8]  = '{0, 0, 1, 3'd0, 32'h1000, 32'd0, 32'h4, 32'h20, 0, 32'h24};
    vecs[9]  = '{0, 1, 1, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h20, 1, 32'h1004};
    vecs[10] = '{0, 1, 0, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0, 1, 32'h10};

    // Reset then free-running fetch.
    step(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    chk("rst_pc", if0.pc, 32'h0);
    chk("rst_cnt", 32'(if0.br_cnt), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk($sformatf("seq_pc%0d", i), if0.pc, 32'(i * 4));
      chk("seq_flush", 32'(if0.flush), 32'h0);
    end

    // BLT taken (signed -1 < 1), then BLTU of the same operands not taken.
    step(0, 0, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40);
    chk("blt_src", 32'(if0.pc_src), 32'h1);
    chk("blt_pc", if0.pc, 32'h50);
    chk("blt_flush", 32'(if0.flush), 32'h1);
    idle();
    chk("blt_flush_drop", 32'(if0.flush), 32'h0);
    step(0, 0, 1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40);
    chk("bltu_src", 32'(if0.pc_src), 32'h0);

    // JALR under stall redirects anyway, then stall holds.
    step(0, 1, 0, 1, 1, 3'd0, 32'h203, 32'd0, 32'h1, 32'h0);
    chk("jalr_tgt", if0.target, 32'h204);
    chk("jalr_pc", if0.pc, 32'h204);
    step(0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    chk("stall_pc", if0.pc, 32'h204);

    // JAL to 0x16: trap without C, plain redirect with C.
    step(0, 0, 0, 1, 0, 3'd0, 0, 0, 32'h6, 32'h10);
    chk("mis_pc", if0.pc, 32'h100);
    chk("mis_trap", 32'(if0.trap), 32'h1);
    chk("mis_taddr", if0.trap_addr, 32'h16);
    chk("mis_flush", 32'(if0.flush), 32'h1);
    chk("c_pc", if1.pc, 32'h16);
    chk("c_trap", 32'(if1.trap), 32'h0);

    // Counter saturation on the 2-bit instance, and funct3=010 counted but never taken.
    step(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 3'd0, 32'd7, 32'd7, 32'h8, 32'h0);
    chk("sat_br", 32'(if2.br_cnt), 32'h3);
    chk("sat_tk", 32'(if2.taken_cnt), 32'h3);
    chk("wide_br", 32'(if0.br_cnt), 32'h5);
    step(0, 0, 1, 0, 0, 3'd2, 32'd7, 32'd7, 32'h8, 32'h0);
    chk("f010_src", 32'(if0.pc_src), 32'h0);
    chk("f010_br", 32'(if0.br_cnt), 32'h6);
    chk("f010_tk", 32'(if0.taken_cnt), 32'h5);

    // Misaligned redirect coinciding with reset is discarded.
    step(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h6, 32'h10);
    chk("rr_pc", if0.pc, 32'h0);
    chk("rr_flush", 32'(if0.flush), 32'h0);
    chk("rr_trap", 32'(if0.trap), 32'h0);

    foreach (vecs[i]) begin
      drive(0, 0, vecs[i].br, vecs[i].j, vecs[i].jr, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].ep);
      comb_check();
      chk($sformatf("vec%0d_src", i), 32'(if0.pc_src), 32'(vecs[i].exp_src));
      chk($sformatf("vec%0d_tgt", i), if0.target, vecs[i].exp_tgt);
      clk_check();
    end

    for (int n = 0; n < 500; n++) begin
      logic [31:0] a, bb, im;
      a  = $urandom;
      bb = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a + $urandom_range(0, 2) - 1);
      im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 3'($urandom),
           a, bb, im, $urandom & 32'hFFFF_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
